// File: rtl/uart_baud_gen_frac.sv
// Fractional oversampling baud generator: os_tick per prescaler period, mid_tick/bit_tick per bit.
// Latency: first os_tick P+1 cycles after the reset/resync load edge; strobes are registered.
// Backpressure: en low freezes all state and suppresses strobes; resync restarts the bit period.
module uart_baud_gen_frac #(
  parameter int INT_W  = 21,
  parameter int FRAC_W = 4,
  parameter int OVS    = 16
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              en,
  input  logic              resync,
  input  logic [INT_W-1:0]  prescaler_int,
  input  logic [FRAC_W-1:0] prescaler_frac,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  localparam int PH_W = (OVS > 2) ? $clog2(OVS) : 1;
  localparam logic [PH_W-1:0] MID_PH  = PH_W'(OVS / 2 - 1);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(OVS - 1);

  // One extra bit on counter/limit so prescaler_int all-ones plus a carry still fits.
  logic [INT_W:0]    counter;
  logic [INT_W:0]    limit;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] frac_l;
  logic [PH_W-1:0]   phase;

  logic [FRAC_W:0]   acc_sum;
  logic              load;
  logic              wrap;

  // Fraction accumulation and the period-end / restart decisions.
  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, frac_l};
    load    = !rst_n || resync;
    wrap    = en && (counter == limit);
  end

  // Cycle counter within one oversample period; limit carries the fractional extra cycle.
  always_ff @(posedge CLK) begin
    if (load) begin
      counter <= '0;
      limit   <= {1'b0, prescaler_int};
    end else if (wrap) begin
      counter <= '0;
      limit   <= {1'b0, prescaler_int} + {{INT_W{1'b0}}, acc_sum[FRAC_W]};
    end else if (en) begin
      counter <= counter + 1'b1;
    end
  end

  // Fraction accumulator and latched fraction; the first period after a load never gets a carry.
  always_ff @(posedge CLK) begin
    if (load) begin
      acc    <= '0;
      frac_l <= prescaler_frac;
    end else if (wrap) begin
      acc    <= acc_sum[FRAC_W-1:0];
      frac_l <= prescaler_frac;
    end
  end

  // Oversample phase within the bit; wraps naturally since OVS is a power of two.
  always_ff @(posedge CLK) begin
    if (load) begin
      phase <= '0;
    end else if (wrap) begin
      phase <= phase + 1'b1;
    end
  end

  // Registered strobes; mid and bit ticks are decoded from the phase being left behind.
  always_ff @(posedge CLK) begin
    if (load || !wrap) begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      os_tick  <= 1'b1;
      mid_tick <= (phase == MID_PH);
      bit_tick <= (phase == LAST_PH);
    end
  end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac with a period-level reference model.
// Model: each period length is P+1 plus the integer carry of the running fraction total.
// Literal tick-time expectations pin both the DUT and the model.
module tb_uart_baud_gen_frac;
  localparam int INT_W  = 5;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;

  logic              CLK = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              resync = 1'b0;
  logic [INT_W-1:0]  p_int = 5'd9;
  logic [FRAC_W-1:0] p_frac = 4'd0;
  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;

  uart_baud_gen_frac #(.INT_W(INT_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
    .CLK(CLK), .rst_n(rst_n), .en(en), .resync(resync),
    .prescaler_int(p_int), .prescaler_frac(p_frac),
    .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: elapsed enabled cycles vs. the length of the current period.
  longint            m_el = 0;
  longint            m_len = 1;
  longint            m_ft = 0;
  longint            m_os = 0;
  logic [FRAC_W-1:0] m_fp = '0;
  logic              e_os = 1'b0;
  logic              e_mid = 1'b0;
  logic              e_bit = 1'b0;

  function automatic longint carry_of(input longint ft, input longint fp);
    return ((ft + fp) >> FRAC_W) - (ft >> FRAC_W);
  endfunction

  always @(posedge CLK) begin
    if (!rst_n || resync) begin
      m_el  <= 0;
      m_len <= longint'(p_int) + 1;
      m_fp  <= p_frac;
      m_ft  <= 0;
      m_os  <= 0;
      e_os  <= 1'b0;
      e_mid <= 1'b0;
      e_bit <= 1'b0;
    end else if (en && (m_el + 1 == m_len)) begin
      m_ft  <= m_ft + longint'(m_fp);
      m_len <= longint'(p_int) + 1 + carry_of(m_ft, longint'(m_fp));
      m_fp  <= p_frac;
      m_el  <= 0;
      m_os  <= m_os + 1;
      e_os  <= 1'b1;
      e_mid <= ((m_os + 1) % OVS) == (OVS / 2);
      e_bit <= ((m_os + 1) % OVS) == 0;
    end else begin
      if (en) m_el <= m_el + 1;
      e_os  <= 1'b0;
      e_mid <= 1'b0;
      e_bit <= 1'b0;
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int os_q[$];
  int mid_q[$];
  int bit_q[$];
  int L;
  int R;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < 0 || i >= q.size()) return -1;
    return q[i];
  endfunction

  function automatic int qhas(input int q[$], input int t);
    foreach (q[i]) if (q[i] == t) return 1;
    return 0;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic clear_logs();
    os_q.delete();
    mid_q.delete();
    bit_q.delete();
  endtask

  task automatic do_reset(input int p, input int f);
    rst_n  = 1'b0;
    resync = 1'b0;
    en     = 1'b1;
    p_int  = INT_W'(p);
    p_frac = FRAC_W'(f);
    step(2);
    rst_n = 1'b1;
    L = cyc;
    clear_logs();
  endtask

  initial begin
    fork
      forever begin
        @(negedge CLK);
        chk("strobes_vs_model", {61'd0, os_tick, mid_tick, bit_tick}, {61'd0, e_os, e_mid, e_bit});
        if (os_tick)  os_q.push_back(cyc);
        if (mid_tick) mid_q.push_back(cyc);
        if (bit_tick) bit_q.push_back(cyc);
      end
    join_none

    // A: integer prescaler only.
    step(2);
    chk("reset_strobes", {61'd0, os_tick, mid_tick, bit_tick}, 64'd0);
    do_reset(9, 0);
    step(340);
    chk("A_first_os", qget(os_q, 0) - L, 10);
    chk("A_os_interval", qget(os_q, 1) - qget(os_q, 0), 10);
    chk("A_os_count", os_q.size(), 34);
    chk("A_mid_time", qget(mid_q, 0) - L, 80);
    chk("A_bit_time", qget(bit_q, 0) - L, 160);
    chk("A_bit_interval", qget(bit_q, 1) - qget(bit_q, 0), 160);

    // B: half-cycle fraction.
    do_reset(9, 8);
    step(520);
    chk("B_os0", qget(os_q, 0) - L, 10);
    chk("B_int1", qget(os_q, 1) - qget(os_q, 0), 10);
    chk("B_int2", qget(os_q, 2) - qget(os_q, 1), 11);
    chk("B_int3", qget(os_q, 3) - qget(os_q, 2), 10);
    chk("B_int4", qget(os_q, 4) - qget(os_q, 3), 11);
    chk("B_mid0", qget(mid_q, 0) - L, 83);
    chk("B_bit0", qget(bit_q, 0) - L, 167);
    chk("B_bit_int1", qget(bit_q, 1) - qget(bit_q, 0), 168);
    chk("B_bit_int2", qget(bit_q, 2) - qget(bit_q, 1), 168);

    // C: all-ones integer prescaler with maximum fraction.
    do_reset(31, 15);
    step(200);
    chk("C_os0", qget(os_q, 0) - L, 32);
    chk("C_int1", qget(os_q, 1) - qget(os_q, 0), 32);
    chk("C_int2", qget(os_q, 2) - qget(os_q, 1), 33);
    chk("C_int3", qget(os_q, 3) - qget(os_q, 2), 33);

    // D: enable dropped for 7 cycles mid-period.
    do_reset(9, 0);
    step(13);
    en = 1'b0;
    step(7);
    en = 1'b1;
    step(100);
    chk("D_stretched", qget(os_q, 1) - qget(os_q, 0), 17);
    chk("D_after", qget(os_q, 2) - qget(os_q, 1), 10);
    chk("D_mid0", qget(mid_q, 0) - L, 87);

    // E: resync mid-period, then resync on a pending wrap.
    do_reset(9, 0);
    step(14);
    resync = 1'b1;
    step(1);
    resync = 1'b0;
    R = cyc;
    step(169);
    chk("E_no_tick_at_resync", qhas(os_q, R), 0);
    chk("E_os_after", qget(os_q, 1) - R, 10);
    chk("E_mid", qget(mid_q, 0) - R, 80);
    chk("E_bit", qget(bit_q, 0) - R, 160);
    resync = 1'b1;
    step(1);
    resync = 1'b0;
    step(20);
    chk("E_wrap_suppressed", qhas(os_q, R + 170), 0);
    chk("E_restart", qhas(os_q, R + 180), 1);

    // F: prescaler change mid-period, then reset mid-bit.
    do_reset(9, 0);
    step(13);
    p_int = 5'd4;
    step(21);
    chk("F_int1", qget(os_q, 1) - qget(os_q, 0), 10);
    chk("F_int2", qget(os_q, 2) - qget(os_q, 1), 5);
    chk("F_int3", qget(os_q, 3) - qget(os_q, 2), 5);
    rst_n = 1'b0;
    step(1);
    chk("F_reset_kills_tick", {61'd0, os_tick, mid_tick, bit_tick}, 64'd0);
    step(1);
    rst_n = 1'b1;
    L = cyc;
    clear_logs();
    step(45);
    chk("F_os0", qget(os_q, 0) - L, 5);
    chk("F_os_int", qget(os_q, 1) - qget(os_q, 0), 5);
    chk("F_mid0", qget(mid_q, 0) - L, 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
